// File: rtl/conv_wb_rtm_writer_gen_if.sv
// Bus bundle between the conv write-back stage, the descriptor FIFO, the PPU array and the RTM.
// Handshakes: a descriptor moves when desc_fifo_rd_en=1 and desc_fifo_empty=0 in the same cycle; a PPU row moves
// whenever ppus_out_vld=1 (no ready); an RTM beat is taken whenever rtm_wr_vld=1 (the RTM never stalls).
interface conv_wb_rtm_writer_gen_if #(
    parameter int S  = 8,
    parameter int R  = 16,
    parameter int AW = 12
);
    logic                desc_fifo_empty;
    logic                desc_fifo_rd_en;
    logic [AW-1:0]       desc_fifo_dout_addr;
    logic [S-1:0]        desc_fifo_dout_mask;
    logic                desc_fifo_dout_last;
    logic [S*R*8-1:0]    ppus_outs;
    logic                ppus_out_vld;
    logic                rtm_wr_vld;
    logic [S-1:0]        rtm_wr_en;
    logic [S*AW-1:0]     rtm_wr_addr;
    logic [S*R*8-1:0]    rtm_din;

    modport master (
        input  desc_fifo_empty, desc_fifo_dout_addr, desc_fifo_dout_mask, desc_fifo_dout_last,
        input  ppus_outs, ppus_out_vld,
        output desc_fifo_rd_en,
        output rtm_wr_vld, rtm_wr_en, rtm_wr_addr, rtm_din
    );

    modport slave (
        output desc_fifo_empty, desc_fifo_dout_addr, desc_fifo_dout_mask, desc_fifo_dout_last,
        output ppus_outs, ppus_out_vld,
        input  desc_fifo_rd_en,
        input  rtm_wr_vld, rtm_wr_en, rtm_wr_addr, rtm_din
    );
endinterface

// File: rtl/conv_wb_rtm_writer_gen.sv
// Conv write-back stage: buffers PPU rows, pairs each with a write-back descriptor and issues one
// masked RTM write per pair. A run is framed by start / done_pulse.
module conv_wb_rtm_writer_gen #(
    parameter int S          = 8,
    parameter int R          = 16,
    parameter int RTM_DEPTH  = 4096,
    parameter int DBUF_DEPTH = 4,
    parameter int DONE_DLY   = 5
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          start,
    output logic                          busy,
    output logic                          done_pulse,
    output logic [31:0]                   wr_cnt,
    output logic                          err_ovf,
    output logic [1:0]                    fsm_state,
    conv_wb_rtm_writer_gen_if.master      bus
);
    localparam int AW = $clog2(RTM_DEPTH);
    localparam int DW = S * R * 8;
    localparam int PW = $clog2(DBUF_DEPTH);
    localparam int CW = $clog2(DONE_DLY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   dbuf [DBUF_DEPTH];
    logic [PW:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]   drain_cnt;
    logic            buf_empty, buf_full;
    logic            pair, push, drop, start_ok, drain_done;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign buf_empty  = (wr_ptr == rd_ptr);
    assign buf_full   = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign pair       = (state == RUN) && !buf_empty && !bus.desc_fifo_empty;
    assign push       = bus.ppus_out_vld && (!buf_full || pair);
    assign drop       = bus.ppus_out_vld && buf_full && !pair;
    assign start_ok   = start && (state == IDLE);
    assign drain_done = (state == DRAIN) && (drain_cnt == CW'(DONE_DLY));
    assign fsm_state  = state;

    always_comb begin
        state_nxt           = state;
        busy                = 1'b0;
        done_pulse          = 1'b0;
        bus.desc_fifo_rd_en = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (pair) begin
                    bus.desc_fifo_rd_en = 1'b1;
                    if (bus.desc_fifo_dout_last) state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    done_pulse = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            // Counts from the cycle of the last write beat, which is the first DRAIN cycle.
            drain_cnt <= (state == DRAIN && !drain_done) ? drain_cnt + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pair) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) dbuf[wr_ptr[PW-1:0]] <= bus.ppus_outs;
    end

    // A drop in the same cycle as an accepted start still flags, so no lost row goes unreported.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_ovf <= 1'b0;
            wr_cnt  <= '0;
        end else begin
            if (drop)          err_ovf <= 1'b1;
            else if (start_ok) err_ovf <= 1'b0;
            if (start_ok)                   wr_cnt <= '0;
            else if (pair && wr_cnt != '1)  wr_cnt <= wr_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rtm_wr_vld  <= 1'b0;
            bus.rtm_wr_en   <= '0;
            bus.rtm_wr_addr <= '0;
            bus.rtm_din     <= '0;
        end else begin
            bus.rtm_wr_vld <= pair;
            bus.rtm_wr_en  <= pair ? ~bus.desc_fifo_dout_mask : '0;
            if (pair) begin
                bus.rtm_wr_addr <= {S{bus.desc_fifo_dout_addr}};
                bus.rtm_din     <= dbuf[rd_ptr[PW-1:0]];
            end
        end
    end
endmodule

// File: tb/tb_conv_wb_rtm_writer_gen.sv
// Directed bench for conv_wb_rtm_writer_gen: table-driven runs plus hand-written corner sequences.
module tb_conv_wb_rtm_writer_gen;
    localparam int S        = 8;
    localparam int R        = 16;
    localparam int AW       = 12;
    localparam int DW       = S * R * 8;
    localparam int EW       = S + S * AW + DW;
    localparam int DONE_DLY = 5;

    typedef struct {
        logic [AW-1:0] addr;
        logic [S-1:0]  mask;
        logic          last;
        logic [S-1:0]  exp_en;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done_pulse, err_ovf;
    logic [31:0] wr_cnt;
    logic [1:0]  fsm_state;
    logic        flush = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cyc = 0;
    int last_beat_cyc = 0;
    int beat_q[$];
    logic [EW-1:0] exp_q[$];
    vec_t vec [0:6];

    logic [AW-1:0] d_addr [64];
    logic [S-1:0]  d_mask [64];
    logic          d_last [64];
    int d_wr = 0;
    int d_rd = 0;

    conv_wb_rtm_writer_gen_if #(.S(S), .R(R), .AW(AW)) bus ();

    conv_wb_rtm_writer_gen #(
        .S(S), .R(R), .RTM_DEPTH(4096), .DBUF_DEPTH(4), .DONE_DLY(DONE_DLY)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .busy       (busy),
        .done_pulse (done_pulse),
        .wr_cnt     (wr_cnt),
        .err_ovf    (err_ovf),
        .fsm_state  (fsm_state),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // FWFT descriptor FIFO model
    assign bus.desc_fifo_empty     = (d_wr == d_rd);
    assign bus.desc_fifo_dout_addr = d_addr[d_rd % 64];
    assign bus.desc_fifo_dout_mask = d_mask[d_rd % 64];
    assign bus.desc_fifo_dout_last = d_last[d_rd % 64];

    always @(posedge clk) begin
        if (flush) d_rd <= d_wr;
        else if (bus.desc_fifo_rd_en && d_wr != d_rd) d_rd <= d_rd + 1;
    end

    function automatic logic [DW-1:0] row_of(int k);
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = {16'(k), 16'(i)} ^ 32'h5A00_0000;
        return r;
    endfunction

    function automatic logic [EW-1:0] pack_exp(logic [S-1:0] en, logic [AW-1:0] a, logic [DW-1:0] row);
        logic [S*AW-1:0] av;
        for (int i = 0; i < S; i++) av[i*AW +: AW] = a;
        return {en, av, row};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: samples 1 unit after each edge; a beat must follow every pop by exactly one cycle.
    always @(posedge clk) begin
        logic pre_rd;
        logic [EW-1:0] e;
        pre_rd = bus.desc_fifo_rd_en & rstn;
        cyc++;
        #1;
        if (rstn) begin
            check("beat_latency", 128'(bus.rtm_wr_vld), 128'(pre_rd));
            if (bus.rtm_wr_vld) begin
                beat_q.push_back(cyc);
                last_beat_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("beat_en", 128'(bus.rtm_wr_en), 128'(e[EW-1 -: S]));
                    check("beat_addr", 128'(bus.rtm_wr_addr), 128'(e[DW +: S*AW]));
                    n_checks++;
                    if (bus.rtm_din !== e[DW-1:0]) begin
                        n_errors++;
                        $display("FAIL beat_data: got %h expected %h (low 64 bits)",
                                 bus.rtm_din[63:0], e[63:0]);
                    end
                end
            end else begin
                check("idle_en", 128'(bus.rtm_wr_en), 128'(0));
            end
        end
    end

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_desc(int a, logic [S-1:0] m, logic l);
        d_addr[d_wr % 64] = AW'(a);
        d_mask[d_wr % 64] = m;
        d_last[d_wr % 64] = l;
        d_wr = d_wr + 1;
    endtask

    task automatic drive_rows(int base, int n);
        for (int i = 0; i < n; i++) begin
            bus.ppus_out_vld = 1'b1;
            bus.ppus_outs    = row_of(base + i);
            @(negedge clk);
        end
        bus.ppus_out_vld = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(int budget);
        int i = 0;
        while (!done_pulse && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", 128'(done_pulse), 128'(1));
        done_cyc = cyc;
    endtask

    task automatic wait_cnt(int n, int budget);
        int i = 0;
        while (wr_cnt != 32'(n) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check("wr_cnt_reached", 128'(wr_cnt), 128'(n));
    endtask

    task automatic run_vecs(int first, int n, int row_base);
        for (int j = 0; j < n; j++) begin
            push_desc(int'(vec[first+j].addr), vec[first+j].mask, vec[first+j].last);
            exp_q.push_back(pack_exp(vec[first+j].exp_en, vec[first+j].addr, row_of(row_base + j)));
        end
        pulse_start();
        check("run_busy", 128'(busy), 128'(1));
        drive_rows(row_base, n);
        wait_done(60);
        check("done_delay", 128'(done_cyc - last_beat_cyc), 128'(DONE_DLY));
        check("run_wr_cnt", 128'(wr_cnt), 128'(n));
        idle(1);
        check("after_done_busy", 128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{addr: 12'd10, mask: 8'h00, last: 1'b0, exp_en: 8'hFF};
        vec[1] = '{addr: 12'd11, mask: 8'h00, last: 1'b0, exp_en: 8'hFF};
        vec[2] = '{addr: 12'd12, mask: 8'h00, last: 1'b0, exp_en: 8'hFF};
        vec[3] = '{addr: 12'd13, mask: 8'h00, last: 1'b1, exp_en: 8'hFF};
        vec[4] = '{addr: 12'd20, mask: 8'hA5, last: 1'b0, exp_en: 8'h5A};
        vec[5] = '{addr: 12'd21, mask: 8'hFF, last: 1'b0, exp_en: 8'h00};
        vec[6] = '{addr: 12'd22, mask: 8'h0F, last: 1'b1, exp_en: 8'hF0};

        bus.ppus_out_vld = 1'b0;
        bus.ppus_outs    = '0;
        idle(3);
        rstn = 1'b1;
        idle(1);

        // reset state
        check("rst_ctrl", 128'({busy, done_pulse, err_ovf, bus.rtm_wr_vld, bus.desc_fifo_rd_en}), 128'(0));
        check("rst_wr_cnt", 128'(wr_cnt), 128'(0));
        check("rst_en", 128'(bus.rtm_wr_en), 128'(0));
        check("rst_addr", 128'(bus.rtm_wr_addr), 128'(0));
        check("rst_din", 128'(|bus.rtm_din), 128'(0));
        check("rst_state", 128'(fsm_state), 128'(0));

        // basic run and per-slot masks
        run_vecs(0, 4, 0);
        run_vecs(4, 3, 10);

        // overflow: 6 rows with no descriptors, buffer holds 4
        drive_rows(100, 4);
        check("ovf_after4", 128'(err_ovf), 128'(0));
        drive_rows(104, 1);
        check("ovf_after5", 128'(err_ovf), 128'(1));
        drive_rows(105, 1);
        check("ovf_sticky", 128'(err_ovf), 128'(1));
        pulse_start();
        check("ovf_cleared", 128'(err_ovf), 128'(0));
        for (int j = 0; j < 4; j++) begin
            push_desc(200 + j, 8'h00, j == 3);
            exp_q.push_back(pack_exp(8'hFF, AW'(200 + j), row_of(100 + j)));
        end
        wait_done(60);
        check("ovf_wr_cnt", 128'(wr_cnt), 128'(4));
        idle(1);

        // rows arriving late
        push_desc(300, 8'h00, 1'b0);
        push_desc(301, 8'h00, 1'b1);
        exp_q.push_back(pack_exp(8'hFF, AW'(300), row_of(110)));
        exp_q.push_back(pack_exp(8'hFF, AW'(301), row_of(111)));
        pulse_start();
        idle(3);
        check("late_no_write", 128'(wr_cnt), 128'(0));
        check("late_no_pop", 128'(bus.desc_fifo_rd_en), 128'(0));
        drive_rows(110, 2);
        wait_done(60);
        idle(1);

        // push+pop while full
        drive_rows(120, 4);
        check("full_preload_ovf", 128'(err_ovf), 128'(0));
        for (int j = 0; j < 8; j++) begin
            push_desc(400 + j, 8'h00, j == 7);
            exp_q.push_back(pack_exp(8'hFF, AW'(400 + j), row_of(120 + j)));
        end
        beat_q.delete();
        pulse_start();
        drive_rows(124, 4);
        wait_done(60);
        check("full_beats", 128'(beat_q.size()), 128'(8));
        if (beat_q.size() == 8) check("full_back_to_back", 128'(beat_q[7] - beat_q[0]), 128'(7));
        check("full_no_ovf", 128'(err_ovf), 128'(0));
        check("full_wr_cnt", 128'(wr_cnt), 128'(8));
        idle(1);

        // start while busy and in the done_pulse cycle; rows sent before start
        drive_rows(130, 2);
        for (int j = 0; j < 3; j++) begin
            push_desc(500 + j, 8'h00, j == 2);
            exp_q.push_back(pack_exp(8'hFF, AW'(500 + j), row_of(130 + j)));
        end
        pulse_start();
        wait_cnt(2, 20);
        pulse_start();
        check("busy_start_busy", 128'(busy), 128'(1));
        check("busy_start_cnt", 128'(wr_cnt), 128'(2));
        idle(2);
        check("busy_start_cnt2", 128'(wr_cnt), 128'(2));
        drive_rows(132, 1);
        wait_done(60);
        check("done_cycle_busy", 128'(busy), 128'(0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_start_busy", 128'(busy), 128'(0));
        check("done_start_cnt", 128'(wr_cnt), 128'(3));
        idle(3);
        check("done_start_idle", 128'({busy, fsm_state}), 128'(0));

        // reset mid-run after 2 of 5 writes
        for (int j = 0; j < 5; j++) push_desc(600 + j, 8'h00, j == 4);
        exp_q.push_back(pack_exp(8'hFF, AW'(600), row_of(140)));
        exp_q.push_back(pack_exp(8'hFF, AW'(601), row_of(141)));
        pulse_start();
        drive_rows(140, 2);
        wait_cnt(2, 20);
        rstn = 1'b0;
        #1;
        check("mid_rst_ctrl", 128'({busy, done_pulse, err_ovf, bus.rtm_wr_vld, bus.desc_fifo_rd_en}), 128'(0));
        check("mid_rst_cnt", 128'(wr_cnt), 128'(0));
        check("mid_rst_en", 128'(bus.rtm_wr_en), 128'(0));
        check("mid_rst_addr", 128'(bus.rtm_wr_addr), 128'(0));
        check("mid_rst_din", 128'(|bus.rtm_din), 128'(0));
        check("mid_rst_desc_left", 128'(d_wr - d_rd), 128'(3));
        check("mid_rst_sb", 128'(exp_q.size()), 128'(0));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle(1);
        rstn = 1'b1;
        idle(2);
        run_vecs(0, 4, 150);

        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
